free_list: RTL

- Physical-register free list that sits directly upstream of the rename stage and drives its `phyreg_flatten` input.
- Each cycle it presents the next NUM_DECODE free physical registers, one group per rename group.
- It pops the group when rename consumes it.
- It accepts up to NUM_COMMIT released registers per cycle from commit and appends them to a circular buffer.

---
 rtl/free_list_if.sv | 28 ++
 rtl/free_list.sv | 98 +++++++++
 2 files changed

// File: rtl/free_list_if.sv
// Rename/commit-facing bundle of the physical-register free list: allocation group
// offered to rename plus the per-slot release bus coming back from commit.
interface free_list_if #(
    parameter int NUM_DECODE = 4,
    parameter int NUM_COMMIT = 4,
    parameter int PHY_WIDTH  = 9,
    parameter int CNT_WIDTH  = 9
);
    // Valid/ready: a group transfers on a cycle where alloc_req and alloc_ready are both
    // high; releases have no back-pressure and every set free_valid bit is taken that cycle.
    logic                             alloc_req;
    logic                             alloc_ready;
    logic [PHY_WIDTH*NUM_DECODE-1:0]  phyreg_flatten;
    logic [NUM_COMMIT-1:0]            free_valid;
    logic [PHY_WIDTH*NUM_COMMIT-1:0]  free_phyreg_flatten;
    logic [CNT_WIDTH-1:0]             free_count;
    logic                             overflow_err;

    modport master (
        output alloc_req, free_valid, free_phyreg_flatten,
        input  alloc_ready, phyreg_flatten, free_count, overflow_err
    );

    modport slave (
        input  alloc_req, free_valid, free_phyreg_flatten,
        output alloc_ready, phyreg_flatten, free_count, overflow_err
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical registers: offers NUM_DECODE entries to rename each
// cycle and appends up to NUM_COMMIT registers released by commit.
module free_list #(
    parameter int NUM_DECODE = 4,
    parameter int NUM_COMMIT = 4,
    parameter int NUM_ARCH   = 31,
    parameter int NUM_PHY    = 380,
    parameter int PHY_WIDTH  = 9,
    parameter int CNT_WIDTH  = 9
) (
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave bus
);
    localparam int DEPTH = NUM_PHY - NUM_ARCH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int PW1   = PTR_W + 1;
    localparam int CW1   = CNT_WIDTH + 1;
    localparam int N_W   = $clog2(NUM_COMMIT + 1);

    localparam logic [PTR_W:0]     DEPTH_P = PW1'(DEPTH);
    localparam logic [CNT_WIDTH:0] DEPTH_C = CW1'(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [PHY_WIDTH-1:0] entry [DEPTH];
    ptr_t                 head;
    ptr_t                 tail;
    logic [CNT_WIDTH-1:0] free_count;
    logic                 overflow_err;

    logic                 fire;
    logic [N_W-1:0]       n;
    ptr_t                 wr_ptr    [NUM_COMMIT];
    logic [PHY_WIDTH-1:0] slot_data [NUM_COMMIT];
    logic [CNT_WIDTH:0]   base_cnt;
    logic [CNT_WIDTH:0]   sum_cnt;
    logic                 ovf;
    ptr_t                 head_next;
    ptr_t                 tail_next;
    logic [CNT_WIDTH-1:0] count_next;

    // DEPTH is not a power of two, so wrapping is an explicit compare-and-subtract.
    function automatic ptr_t wrap_add(input ptr_t base, input logic [PTR_W:0] off);
        logic [PTR_W:0] s;
        s = {1'b0, base} + off;
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PTR_W-1:0];
    endfunction

    assign bus.alloc_ready  = (free_count >= CNT_WIDTH'(NUM_DECODE));
    assign bus.free_count   = free_count;
    assign bus.overflow_err = overflow_err;

    always_comb begin
        bus.phyreg_flatten = '0;
        for (int k = 0; k < NUM_DECODE; k++) begin
            bus.phyreg_flatten[(NUM_DECODE-1-k)*PHY_WIDTH +: PHY_WIDTH] = entry[wrap_add(head, PW1'(k))];
        end
    end

    always_comb begin
        fire = bus.alloc_req & bus.alloc_ready;
        n    = '0;
        // Each valid slot lands at tail plus the number of valid slots below it.
        for (int s = 0; s < NUM_COMMIT; s++) begin
            slot_data[s] = bus.free_phyreg_flatten[(NUM_COMMIT-1-s)*PHY_WIDTH +: PHY_WIDTH];
            wr_ptr[s]    = wrap_add(tail, PW1'(n));
            if (bus.free_valid[s]) n = n + 1'b1;
        end
        base_cnt   = {1'b0, free_count} - (fire ? CW1'(NUM_DECODE) : '0);
        sum_cnt    = base_cnt + CW1'(n);
        ovf        = (sum_cnt > DEPTH_C);
        count_next = ovf ? base_cnt[CNT_WIDTH-1:0] : sum_cnt[CNT_WIDTH-1:0];
        tail_next  = ovf ? tail : wrap_add(tail, PW1'(n));
        head_next  = fire ? wrap_add(head, PW1'(NUM_DECODE)) : head;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= PHY_WIDTH'(NUM_ARCH + i);
            head         <= '0;
            tail         <= '0;
            free_count   <= DEPTH_C[CNT_WIDTH-1:0];
            overflow_err <= 1'b0;
        end else begin
            if (!ovf) begin
                for (int s = 0; s < NUM_COMMIT; s++) begin
                    if (bus.free_valid[s]) entry[wr_ptr[s]] <= slot_data[s];
                end
            end
            head       <= head_next;
            tail       <= tail_next;
            free_count <= count_next;
            if (ovf) overflow_err <= 1'b1;
        end
    end
endmodule
